mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Memory-stage access controller between the EX/MEM and MEM/WB pipeline registers.
//   - Turns the MEM-stage controls (mem_enable, mem_rw, mem_size) into a request/ready transaction on the data RAM.
//   - Stalls the pipeline while a transaction is outstanding.
//   - Aligns byte loads and stores; flags misaligned word accesses.
// PARAMETERS
//   ADDR_WIDTH      32  byte-address width
//   TIMEOUT_CYCLES  16  ACCESS cycles without dm_ready_in before abort (MEM_TIMEOUT_EN only); >=1
// PORTS
//   clk                in   1   clock; all state updates on posedge
//   reset              in   1   synchronous, active-high
//   mem_enable_in      in   1   MEM-stage access request
//   mem_rw_in          in   1   1=store, 0=load
//   mem_size_in        in   1   1=byte, 0=word
//   mem_addr_in        in   ADDR_WIDTH  byte address
//   mem_wdata_in       in   32  store data; byte store uses [7:0]
//   stall_out          out  1   hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//   load_data_out      out  32  load result to MEM/WB (registered)
//   load_valid_out     out  1   1-cycle pulse: load_data_out valid
//   align_fault_out    out  1   1-cycle pulse: misaligned word access dropped
//   timeout_fault_out  out  1   1-cycle pulse: access aborted (tied 0 without MEM_TIMEOUT_EN)
//   dm_req_out         out  1   RAM request, held until ready
//   dm_we_out          out  1   RAM write enable
//   dm_addr_out        out  ADDR_WIDTH  word-aligned: {addr[AW-1:2],2'b00}
//   dm_be_out          out  4   byte enables, little-endian
//   dm_wdata_out       out  32  RAM write data
//   dm_rdata_in        in   32  RAM read data, valid with dm_ready_in
//   dm_ready_in        in   1   RAM completes request this cycle
// BEHAVIOUR
//   Reset values
//   - All registered outputs are 0 and state = IDLE.
//   - Reset mid-transaction drops dm_req_out at that edge and discards the access; no fault pulse.
//   FSM states: IDLE, ACCESS, DONE
//   - IDLE, mem_enable_in=1, aligned: capture addr/rw/size/wdata; stall_out=1; next = ACCESS.
//   - IDLE, mem_enable_in=1, mem_size_in=0, addr[1:0]!=0:
//       no RAM access; stall_out=0; align_fault_out=1 on the next cycle; stay IDLE.
//   - IDLE, mem_enable_in=0: stall_out=0; outputs idle.
//   - ACCESS: dm_req_out=1; dm_we/addr/be/wdata driven from captured values and stable until ready; stall_out=1.
//       dm_ready_in=1: a load latches its data into load_data_out; next = DONE.
//   - DONE: stall_out=0; load_valid_out=1 for loads only; next = IDLE.
//       mem_enable_in is ignored in DONE: it still reflects the instruction just completed,
//       and EX/MEM advances at the end of this cycle.
//   Latency
//   - Zero-wait RAM: 2 stall cycles (IDLE-accept, ACCESS), then DONE.
//   - Each cycle dm_ready_in stays low adds one stall cycle.
//   Byte lanes (lane = addr[1:0])
//   - Byte store: dm_be_out = 4'b0001<<lane; dm_wdata_out = {4{wdata[7:0]}}.
//   - Word store: dm_be_out = 4'hF; dm_wdata_out = wdata. Loads drive dm_be_out = 4'hF.
//   - Byte load: load_data_out = {24'b0, dm_rdata_in[8*lane +: 8]} (zero-extend).
//   - Word load: load_data_out = dm_rdata_in.
//   - load_data_out holds its value until the next load completes.
// CONFIGURATION
//   MEM_TIMEOUT_EN defined
//   - A counter clears on ACCESS entry and increments each ACCESS cycle with dm_ready_in=0.
//   - When the count reaches TIMEOUT_CYCLES: drop dm_req_out, go to DONE, pulse timeout_fault_out.
//     Result: load_data_out=0, load_valid_out=0.
//   - dm_ready_in=1 on the same cycle as the limit: the access completes normally, no fault.
//   MEM_TIMEOUT_EN undefined
//   - ACCESS waits indefinitely; no counter logic; timeout_fault_out tied 0.
// TESTING
//   - Reset, then idle: all outputs 0; stall_out=0 while mem_enable_in=0.
//   - Word load addr 0x100, ready held high, rdata 0xDEADBEEF:
//       stall 2 cycles; DONE gives load_valid_out=1, load_data_out=0xDEADBEEF.
//   - Byte store addr 0x203, wdata 0x000000A5, ready after 3 waits:
//       dm_be_out=4'b1000, dm_wdata_out=0xA5A5A5A5, dm_addr_out=0x200, 5 stall cycles.
//   - Byte load addr 0x102, rdata 0x11223344 -> load_data_out=0x00000022.
//     Word load addr 0x102 -> align_fault_out pulse, dm_req_out never set.
//   - Reset asserted in ACCESS with ready=0 -> next cycle IDLE, dm_req_out=0, stall_out=0.
//   - MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never set:
//       dm_req_out high 4 cycles, then timeout_fault_out pulse, stall releases.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage access controller for the data RAM
//
// Turns the MEM-stage controls into a request/ready transaction on the data
// RAM, stalls the pipeline while the transaction is outstanding, aligns byte
// loads/stores and drops misaligned word accesses with a fault pulse.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : an ACCESS that sees no dm_ready_in for TIMEOUT_CYCLES cycles
//               is aborted and timeout_fault_out pulses.
//   undefined : ACCESS waits indefinitely; timeout_fault_out is tied 0.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   mem_enable_in       MEM-stage access request
//   mem_rw_in           1 = store, 0 = load
//   mem_size_in         1 = byte, 0 = word
//   mem_addr_in         byte address
//   mem_wdata_in        store data (byte store uses [7:0])
//   stall_out           combinational pipeline hold
//   load_data_out       registered load result, held until the next load
//   load_valid_out      1-cycle pulse, load_data_out valid
//   align_fault_out     1-cycle pulse, misaligned word access dropped
//   timeout_fault_out   1-cycle pulse, access aborted
//   dm_req_out          RAM request, held until ready
//   dm_we_out           RAM write enable
//   dm_addr_out         word-aligned RAM address
//   dm_be_out           little-endian byte enables
//   dm_wdata_out        RAM write data
//   dm_rdata_in         RAM read data, valid with dm_ready_in
//   dm_ready_in         RAM completes the request this cycle

module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_enable_in,
    input  logic                  mem_rw_in,
    input  logic                  mem_size_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [31:0]           mem_wdata_in,
    output logic                  stall_out,
    output logic [31:0]           load_data_out,
    output logic                  load_valid_out,
    output logic                  align_fault_out,
    output logic                  timeout_fault_out,
    output logic                  dm_req_out,
    output logic                  dm_we_out,
    output logic [ADDR_WIDTH-1:0] dm_addr_out,
    output logic [3:0]            dm_be_out,
    output logic [31:0]           dm_wdata_out,
    input  logic [31:0]           dm_rdata_in,
    input  logic                  dm_ready_in
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Transaction captured at accept; the RAM side is driven only from these
    // so dm_* stays stable even if the pipeline inputs move.
    logic                  rw_q;
    logic                  size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic                  load_valid_q;
    logic                  align_fault_q;
    logic [31:0]           load_data_q;

    logic misaligned;
    logic accept;
    logic in_access;
    logic limit_hit;
    logic [31:0] rdata_shifted;

    assign misaligned    = mem_enable_in && !mem_size_in && (mem_addr_in[1:0] != 2'b00);
    assign accept        = (state_q == S_IDLE) && mem_enable_in && !misaligned;
    assign in_access     = (state_q == S_ACCESS);
    assign rdata_shifted = dm_rdata_in >> {addr_q[1:0], 3'b000};

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_fault_q;

    // The limit is reached on the ACCESS cycle whose missing ready would make
    // the count equal TIMEOUT_CYCLES; a ready on that same cycle still wins.
    assign limit_hit = in_access && !dm_ready_in
                       && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q      <= '0;
            timeout_fault_q <= 1'b0;
        end else begin
            timeout_fault_q <= limit_hit;
            if (accept) begin
                wait_cnt_q <= '0;
            end else if (in_access && !dm_ready_in) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    assign timeout_fault_out = timeout_fault_q;
`else
    assign limit_hit         = 1'b0;
    assign timeout_fault_out = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        stall_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall_out = 1'b1;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                stall_out = 1'b1;
                if (dm_ready_in || limit_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // mem_enable_in still shows the instruction just finished.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rw_q          <= 1'b0;
            size_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            load_valid_q  <= 1'b0;
            align_fault_q <= 1'b0;
            load_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            load_valid_q  <= 1'b0;
            align_fault_q <= (state_q == S_IDLE) && misaligned;
            if (accept) begin
                rw_q    <= mem_rw_in;
                size_q  <= mem_size_in;
                addr_q  <= mem_addr_in;
                wdata_q <= mem_wdata_in;
            end
            if (in_access) begin
                if (dm_ready_in) begin
                    if (!rw_q) begin
                        load_data_q  <= size_q ? {24'b0, rdata_shifted[7:0]} : dm_rdata_in;
                        load_valid_q <= 1'b1;
                    end
                end else if (limit_hit) begin
                    load_data_q <= '0;
                end
            end
        end
    end

    assign load_data_out   = load_data_q;
    assign load_valid_out  = load_valid_q;
    assign align_fault_out = align_fault_q;

    // RAM side is quiet outside ACCESS; byte enables only narrow for byte stores.
    assign dm_req_out   = in_access;
    assign dm_we_out    = in_access && rw_q;
    assign dm_addr_out  = in_access ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dm_be_out    = !in_access ? 4'h0
                        : (rw_q && size_q) ? (4'b0001 << addr_q[1:0])
                        : 4'hF;
    assign dm_wdata_out = !(in_access && rw_q) ? 32'h0
                        : size_q ? {4{wdata_q[7:0]}}
                        : wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit

module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_enable_in;
    logic        mem_rw_in;
    logic        mem_size_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        align_fault_out;
    logic        timeout_fault_out;
    logic        dm_req_out;
    logic        dm_we_out;
    logic [31:0] dm_addr_out;
    logic [3:0]  dm_be_out;
    logic [31:0] dm_wdata_out;
    logic [31:0] dm_rdata_in;
    logic        dm_ready_in;

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_enable_in     (mem_enable_in),
        .mem_rw_in         (mem_rw_in),
        .mem_size_in       (mem_size_in),
        .mem_addr_in       (mem_addr_in),
        .mem_wdata_in      (mem_wdata_in),
        .stall_out         (stall_out),
        .load_data_out     (load_data_out),
        .load_valid_out    (load_valid_out),
        .align_fault_out   (align_fault_out),
        .timeout_fault_out (timeout_fault_out),
        .dm_req_out        (dm_req_out),
        .dm_we_out         (dm_we_out),
        .dm_addr_out       (dm_addr_out),
        .dm_be_out         (dm_be_out),
        .dm_wdata_out      (dm_wdata_out),
        .dm_rdata_in       (dm_rdata_in),
        .dm_ready_in       (dm_ready_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        lvalid;
        logic [31:0] ldata;
        logic        af;
        logic        tf;
    } exp_t;

    exp_t        cur;
    logic        chk_en = 1'b0;
    logic [31:0] last_load = 32'h0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          stall_seen = 0;
    int          req_seen = 0;
    logic [3:0]  seen_be = 4'h0;
    logic [31:0] seen_wdata = 32'h0;
    logic [31:0] seen_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.stall = 1'b0; e.req = 1'b0; e.we = 1'b0; e.addr = 32'h0; e.be = 4'h0;
        e.wdata = 32'h0; e.lvalid = 1'b0; e.ldata = last_load; e.af = 1'b0; e.tf = 1'b0;
        return e;
    endfunction

    // Single compare process: every cycle the expectation is live.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_out", 32'(stall_out), 32'(cur.stall));
            chk("dm_req_out", 32'(dm_req_out), 32'(cur.req));
            chk("dm_we_out", 32'(dm_we_out), 32'(cur.we));
            chk("dm_addr_out", dm_addr_out, cur.addr);
            chk("dm_be_out", 32'(dm_be_out), 32'(cur.be));
            chk("dm_wdata_out", dm_wdata_out, cur.wdata);
            chk("load_valid_out", 32'(load_valid_out), 32'(cur.lvalid));
            chk("load_data_out", load_data_out, cur.ldata);
            chk("align_fault_out", 32'(align_fault_out), 32'(cur.af));
            chk("timeout_fault_out", 32'(timeout_fault_out), 32'(cur.tf));
            if (stall_out) stall_seen++;
            if (dm_req_out) begin
                req_seen++;
                seen_be    = dm_be_out;
                seen_wdata = dm_wdata_out;
                seen_addr  = dm_addr_out;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one MEM-stage access and builds the cycle-by-cycle expectation
    // from the transaction timeline: accept, (waits+1) request cycles, done.
    task automatic do_access(input logic rw, input logic size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        logic [1:0] lane;
        bit         tmo;
        int         ncyc;
        lane = addr[1:0];
        mem_enable_in = 1'b1; mem_rw_in = rw; mem_size_in = size;
        mem_addr_in = addr; mem_wdata_in = wdata;
        dm_ready_in = 1'b0; dm_rdata_in = 32'h0;
        if (!size && lane != 2'd0) begin
            cur = idle_exp();
            step();
            mem_enable_in = 1'b0;
            cur = idle_exp();
            cur.af = 1'b1;
            step();
            return;
        end
        cur = idle_exp();
        cur.stall = 1'b1;
        step();
`ifdef MEM_TIMEOUT_EN
        tmo = (waits >= TO);
`else
        tmo = 1'b0;
`endif
        ncyc = tmo ? TO : waits + 1;
        for (int i = 1; i <= ncyc; i++) begin
            dm_ready_in = !tmo && (i == waits + 1);
            dm_rdata_in = dm_ready_in ? rdata : (32'hBAD0_0000 | i);
            cur = idle_exp();
            cur.stall = 1'b1;
            cur.req   = 1'b1;
            cur.we    = rw;
            cur.addr  = addr & 32'hFFFF_FFFC;
            cur.be    = (rw && size) ? (4'b0001 << lane) : 4'hF;
            cur.wdata = !rw ? 32'h0 : size ? {4{wdata[7:0]}} : wdata;
            step();
        end
        dm_ready_in = 1'b0;
        dm_rdata_in = 32'h0;
        if (tmo) begin
            last_load = 32'h0;
            cur = idle_exp();
            cur.tf = 1'b1;
        end else begin
            if (!rw) last_load = size ? ((rdata >> (8 * lane)) & 32'hFF) : rdata;
            cur = idle_exp();
            cur.lvalid = !rw;
        end
        step();
        mem_enable_in = 1'b0;
        cur = idle_exp();
        step();
    endtask

    int s0, r0;

    initial begin
        reset = 1'b1;
        mem_enable_in = 1'b0; mem_rw_in = 1'b0; mem_size_in = 1'b0;
        mem_addr_in = 32'h0; mem_wdata_in = 32'h0;
        dm_rdata_in = 32'h0; dm_ready_in = 1'b0;
        cur = idle_exp();
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Word load, zero-wait RAM
        s0 = stall_seen;
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        chk("lit_wl_stall_cycles", 32'(stall_seen - s0), 32'd2);
        chk("lit_wl_data", load_data_out, 32'hDEADBEEF);

        // Byte store lane 3, three wait cycles
        s0 = stall_seen;
        do_access(1'b1, 1'b1, 32'h203, 32'h0000_00A5, 32'h0, 3);
        chk("lit_bs_stall_cycles", 32'(stall_seen - s0), 32'd5);
        chk("lit_bs_be", 32'(seen_be), 32'h8);
        chk("lit_bs_wdata", seen_wdata, 32'hA5A5A5A5);
        chk("lit_bs_addr", seen_addr, 32'h200);
        chk("lit_bs_ldata_held", load_data_out, 32'hDEADBEEF);

        // Byte load lane 2
        do_access(1'b0, 1'b1, 32'h102, 32'h0, 32'h11223344, 1);
        chk("lit_bl_data", load_data_out, 32'h00000022);

        // Misaligned word load / store: fault, no RAM request
        r0 = req_seen;
        do_access(1'b0, 1'b0, 32'h102, 32'h0, 32'h0, 0);
        do_access(1'b1, 1'b0, 32'h101, 32'h12345678, 32'h0, 0);
        chk("lit_misalign_no_req", 32'(req_seen - r0), 32'd0);

        // Mixed lanes and sizes
        do_access(1'b1, 1'b0, 32'h10C, 32'hCAFEF00D, 32'h0, 2);
        do_access(1'b1, 1'b1, 32'h201, 32'h1234567F, 32'h0, 0);
        chk("lit_bs1_be", 32'(seen_be), 32'h2);
        do_access(1'b0, 1'b1, 32'h100, 32'h0, 32'h8899AABB, 0);
        chk("lit_bl0_data", load_data_out, 32'h000000BB);
        do_access(1'b0, 1'b1, 32'h3FF, 32'h0, 32'h80FF_0102, 2);
        chk("lit_bl3_data", load_data_out, 32'h00000080);

        // Reset while ACCESS waits for ready
        mem_enable_in = 1'b1; mem_rw_in = 1'b0; mem_size_in = 1'b0;
        mem_addr_in = 32'h300; dm_ready_in = 1'b0;
        cur = idle_exp(); cur.stall = 1'b1;
        step();
        cur = idle_exp(); cur.stall = 1'b1; cur.req = 1'b1; cur.addr = 32'h300; cur.be = 4'hF;
        step();
        reset = 1'b1; mem_enable_in = 1'b0;
        step();
        reset = 1'b0;
        last_load = 32'h0;
        cur = idle_exp();
        chk("lit_rst_req", 32'(dm_req_out), 32'd0);
        chk("lit_rst_stall", 32'(stall_out), 32'd0);
        step();
        step();

`ifdef MEM_TIMEOUT_EN
        // Ready on the limit cycle completes normally
        do_access(1'b0, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, TO - 1);
        chk("lit_edge_data", load_data_out, 32'h0BADF00D);
        // Ready never arrives
        r0 = req_seen;
        do_access(1'b0, 1'b0, 32'h108, 32'h0, 32'h0, 50);
        chk("lit_to_req_cycles", 32'(req_seen - r0), 32'(TO));
        chk("lit_to_data", load_data_out, 32'h0);
`endif

        chk_en = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
